// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin access arbiter for a shared load/save register bank.
// Each transaction runs IDLE -> ACCESS -> DONE; all strobes and responses are registered.
module reg_bank_arbiter #(
    parameter int UUID       = 0,
    parameter     NAME       = "",
    parameter int NUM_REQ    = 4,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           rsp_err,
    output logic [NUM_REGS-1:0]            reg_rd_en,
    output logic [NUM_REGS-1:0]            reg_wr_en,
    output logic [DATA_WIDTH-1:0]          reg_wdata,
    input  logic [DATA_WIDTH-1:0]          reg_rdata,
    output logic                           busy
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t                r_state;
    logic [IW-1:0]         r_rr_ptr;
    logic [IW-1:0]         r_win;
    logic                  r_we;
    logic                  r_err;
    logic [NUM_REQ-1:0]    r_gnt;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic [NUM_REGS-1:0]   r_rd_en;
    logic [NUM_REGS-1:0]   r_wr_en;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_busy;

    logic                  w_found;
    logic [IW-1:0]         w_win;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_in_range;

    // Round-robin search starting at r_rr_ptr; also mux out the winner's request fields.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_win   = IW'(idx);
                w_we    = req_we[idx];
                w_addr  = req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
                w_wdata = req_wdata[idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        w_in_range = ({1'b0, w_addr} < (ADDR_WIDTH+1)'(NUM_REGS));
    end

    // Transaction FSM; strobes for ACCESS are set on entry so they are glitch-free registers
    // that the async reset clears immediately, preventing a partial save.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_win       <= '0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rd_en     <= '0;
            r_wr_en     <= '0;
            r_wdata     <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_win   <= w_win;
                        r_we    <= w_we;
                        r_err   <= !w_in_range;
                        r_gnt   <= NUM_REQ'(1) << w_win;
                        r_busy  <= 1'b1;
                        if (w_in_range) begin
                            if (w_we) begin
                                r_wr_en <= NUM_REGS'(1) << w_addr;
                                r_wdata <= w_wdata;
                            end else begin
                                r_rd_en <= NUM_REGS'(1) << w_addr;
                            end
                        end
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_gnt   <= '0;
                    r_rd_en <= '0;
                    r_wr_en <= '0;
                    r_wdata <= '0;
                    // Out-of-range reads return zero; writes leave the last read data alone.
                    if (!r_we)
                        r_rsp_rdata <= r_err ? '0 : reg_rdata;
                    r_rsp_valid <= NUM_REQ'(1) << r_win;
                    r_rsp_err   <= r_err;
                    r_state     <= S_DONE;
                end
                default: begin
                    r_rsp_valid <= '0;
                    r_rsp_err   <= 1'b0;
                    r_rr_ptr    <= (r_win == IW'(NUM_REQ-1)) ? '0 : r_win + 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign reg_rd_en = r_rd_en;
    assign reg_wr_en = r_wr_en;
    assign reg_wdata = r_wdata;
    assign busy      = r_busy;
endmodule
